// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory handshake timeout, illegal-opcode trap, halt and a retired-instruction counter.
module multicycle_controller #(
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned TIMEOUT     = 16,
    parameter bit          EXT_EN      = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             JalrSel,
    output logic             JmpSel,
    output logic [1:0]       ALUOp,
    output logic             flag_halt,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StError  = 3'd6,
        StBad    = 3'd7
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_HALT = 7'b0000001;

    state_e           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retire_q;
    logic             run_q;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [10:0]      ctrl_q;
    logic             ready;
    logic             wait_last;
    logic             retire_inc;

    // Moore control word: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
    // JalrSel, JmpSel, ALUOp[1:0], flag_halt}
    function automatic logic [10:0] moore_ctrl(state_e s, logic [6:0] op);
        logic       alu_src, m2r, rw, mr, mw, br, jalr, jmp, halt;
        logic [1:0] aop;
        {alu_src, m2r, rw, mr, mw, br, jalr, jmp, halt} = '0;
        aop = 2'b00;
        case (s)
            StFetch: mr = 1'b1;
            StExec: begin
                alu_src = op inside {OP_LW, OP_SW, OP_I, OP_JALR, OP_U};
                aop[1]  = op inside {OP_R, OP_I, OP_U};
                aop[0]  = op inside {OP_BR, OP_U};
                br      = (op == OP_BR);
                jmp     = (op == OP_JAL) || (op == OP_JALR);
                rw      = jmp;
                jalr    = (op == OP_JALR);
            end
            StMem: begin
                mr = (op == OP_LW);
                mw = (op == OP_SW);
            end
            StWb: begin
                rw  = 1'b1;
                m2r = (op == OP_LW);
            end
            StHalt:  halt = 1'b1;
            default: ;
        endcase
        return {alu_src, m2r, rw, mr, mw, br, jalr, jmp, aop, halt};
    endfunction

    function automatic logic is_legal(logic [6:0] op);
        if (op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR}) return 1'b1;
        if (op inside {OP_U, OP_JAL, OP_JALR})          return EXT_EN;
        return 1'b0;
    endfunction

    always_comb begin
        ready      = MEM_WAIT_EN ? mem_ready : 1'b1;
        wait_last  = (wait_q == 8'(TIMEOUT - 1));
        state_d    = state_q;
        opcode_d   = opcode_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        case (state_q)
            // run_q holds off the handshake until one full edge after reset release
            StFetch: begin
                if (run_q) begin
                    if (ready) begin
                        state_d = StDecode;
                    end else if (wait_last) begin
                        state_d   = StError;
                        timeout_d = 1'b1;
                    end
                end
            end
            StDecode: begin
                opcode_d = Opcode;
                if (Opcode == OP_HALT) begin
                    state_d = StHalt;
                end else if (is_legal(Opcode)) begin
                    state_d = StExec;
                end else begin
                    state_d   = StError;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                if (opcode_q inside {OP_R, OP_I, OP_U})             state_d = StWb;
                else if (opcode_q inside {OP_LW, OP_SW})            state_d = StMem;
                else if (opcode_q inside {OP_BR, OP_JAL, OP_JALR})  state_d = StFetch;
                else                                                state_d = StError;
            end
            StMem: begin
                if (ready) begin
                    state_d = (opcode_q == OP_LW) ? StWb : StFetch;
                end else if (wait_last) begin
                    state_d   = StError;
                    timeout_d = 1'b1;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            StError: state_d = StError;
            default: state_d = StError;
        endcase

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (!ready && ((state_q == StFetch && run_q) || state_q == StMem)) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end

        retire_inc = (state_d == StFetch) && (state_q inside {StExec, StMem, StWb});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            opcode_q  <= 7'd0;
            wait_q    <= 8'd0;
            retire_q  <= '0;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            ctrl_q    <= moore_ctrl(StFetch, 7'd0);
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            wait_q    <= wait_d;
            run_q     <= 1'b1;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            ctrl_q    <= moore_ctrl(state_d, opcode_d);
            if (retire_inc) begin
                retire_q <= retire_q + CNT_W'(1);
            end
        end
    end

    assign {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
            JalrSel, JmpSel, ALUOp, flag_halt} = ctrl_q;

    // Instruction-register load and PC advance coincide with the fetch handshake
    assign IRWrite     = run_q && (state_q == StFetch) && ready;
    assign PCWrite     = IRWrite;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;
    assign retire_cnt  = retire_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters (name, default, meaning):
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constantly 1.
- TIMEOUT, 16, maximum wait cycles for mem_ready in FETCH or MEM; range 1..255.
- EXT_EN, 1, 1 = JAL, JALR and LUI are legal; 0 = they decode as illegal.
- CNT_W, 32, width of retire_cnt.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- Opcode, in, 7, instruction opcode; sampled only in DECODE.
- mem_ready, in, 1, memory handshake acknowledge.
- PCWrite, out, 1, advance PC.
- IRWrite, out, 1, load instruction register.
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, JmpSel, out, 1 each, datapath controls.
- ALUOp, out, 2, ALU operation class.
- flag_halt, out, 1, halted.
- illegal, out, 1, illegal-opcode error.
- mem_timeout, out, 1, memory-timeout error.
- state, out, 3, current state code.
- retire_cnt, out, CNT_W, count of retired instructions.

Function
REQ-004 States and codes SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6; code 7 SHALL go to ERROR on the next clock.
REQ-005 Opcode encodings SHALL be:
- R=0110011, I=0010011, U(LUI)=0110111
- LW=0000011, SW=0100011, BR=1100011
- JALR=1100111, JAL=1101111, HALT=0000001.
REQ-006 FETCH SHALL hold MemRead=1 until mem_ready=1; on that cycle it SHALL pulse IRWrite=1 and PCWrite=1 and go to DECODE.
REQ-007 DECODE SHALL latch Opcode into an internal register. Next state:
- HALT opcode -> HALT.
- Unlisted opcode, or J/U opcode with EXT_EN=0 -> ERROR with illegal=1.
- Otherwise -> EXEC.
REQ-008 EXEC outputs SHALL derive from the latched opcode:
- ALUSrc=1 for LW, SW, I, JALR, U.
- ALUOp[1]=1 for R, I, U; ALUOp[0]=1 for BR, U.
REQ-009 EXEC next state:
- R, I, U -> WB.
- LW, SW -> MEM.
- BR -> FETCH with Branch=1.
- JAL/JALR -> FETCH with JmpSel=1, RegWrite=1, and JalrSel=1 for JALR only.
REQ-010 MEM SHALL hold MemRead=1 (LW) or MemWrite=1 (SW) until mem_ready=1; then LW -> WB and SW -> FETCH.
REQ-011 WB SHALL assert RegWrite=1, with MemtoReg=1 for LW only, and go to FETCH.
REQ-012 Every output not named for a state SHALL be 0 in that state; outputs SHALL depend only on the state and the latched opcode (Moore).
REQ-013 retire_cnt SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, and SHALL wrap from all-ones to 0.
REQ-014 A wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle with mem_ready=0.
REQ-015 When the wait counter reaches TIMEOUT, the next state SHALL be ERROR with mem_timeout=1; if mem_ready=1 on that same cycle, the handshake SHALL win.
REQ-016 HALT and ERROR SHALL be sticky until reset and SHALL ignore mem_ready and Opcode; flag_halt=1 in HALT.
REQ-017 illegal and mem_timeout SHALL be mutually exclusive and remain set while in ERROR.
REQ-018 Latency with zero-wait memory SHALL be: R/I/U 4 cycles, LW 5, SW 4, BR 3, JAL/JALR 3.

Reset
REQ-019 While reset=0, the block SHALL immediately set state=FETCH, latched opcode=0, wait counter=0 and retire_cnt=0, with all flags and controls 0 except MemRead=1 (FETCH).
REQ-020 Reset asserted mid-instruction, including mid-MEM, SHALL abort the instruction with no RegWrite or retire increment.
REQ-021 The first FETCH cycle SHALL follow the first clk rising edge after reset=1.

Verification
REQ-022 R-type 0110011 with mem_ready=1 -> states 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=10 in EXEC; retire_cnt 0->1.
REQ-023 LW with mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles with MemRead=1; WB has MemtoReg=1; total 8 cycles.
REQ-024 TIMEOUT=4, mem_ready=0 in FETCH -> ERROR after 4 wait cycles, mem_timeout=1 and sticky for 10 further cycles.
REQ-025 EXT_EN=0 with Opcode=1101111 -> ERROR, illegal=1; with EXT_EN=1 -> JmpSel=1, RegWrite=1 in EXEC, JalrSel=0.
REQ-026 HALT opcode 0000001 -> flag_halt=1 held indefinitely; reset pulse -> FETCH with retire_cnt=0.
REQ-027 CNT_W=4, 17 back-to-back BR instructions -> retire_cnt wraps to 1.
